// File: rtl/token_decimator_ctrl_if.sv
// Handshake and token bus for token_decimator_ctrl: serial token in/out,
// ratio configuration handshake, and token statistics.
interface token_decimator_ctrl_if #(
   parameter int CNT_W  = 4,
   parameter int STAT_W = 8
);
   logic              a;
   logic              b;
   logic              cfg_valid;
   logic [CNT_W-1:0]  cfg_ratio;
   logic              cfg_ready;
   logic              active;
   logic              stat_clr;
   logic [STAT_W-1:0] tok_in_cnt;
   logic [STAT_W-1:0] tok_out_cnt;

   modport master (
      output a, cfg_valid, cfg_ratio, stat_clr,
      input  b, cfg_ready, active, tok_in_cnt, tok_out_cnt
   );

   modport slave (
      input  a, cfg_valid, cfg_ratio, stat_clr,
      output b, cfg_ready, active, tok_in_cnt, tok_out_cnt
   );
endinterface

// File: rtl/token_decimator_ctrl.sv
// Programmable serial token decimator: passes every Nth token, ratio changes land on period boundaries.
// Define TOKEN_DECIM_STATS_EN to compile in the saturating token statistics counters.
module token_decimator_ctrl #(
   parameter int CNT_W  = 4,
   parameter int STAT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   token_decimator_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_PEND = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] ratio_q, ratio_d;
   logic [CNT_W-1:0] pend_ratio_q, pend_ratio_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             b_q, b_d;

   logic accept;
   logic tok_proc;
   logic emit;
   logic boundary;

   assign bus.cfg_ready = (state_q != S_PEND);
   assign bus.active    = (state_q != S_IDLE);
   assign bus.b         = b_q;

   assign accept   = bus.cfg_valid && bus.cfg_ready;
   assign tok_proc = bus.a && (state_q != S_IDLE);
   assign emit     = tok_proc && (cnt_q == ratio_q - CNT_W'(1));
   // A period boundary: the current period closes now, or no period has started.
   assign boundary = emit || ((cnt_q == '0) && !bus.a);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      state_d      = state_q;
      ratio_d      = ratio_q;
      pend_ratio_d = pend_ratio_q;
      cnt_d        = cnt_q;
      b_d          = 1'b0;

      if (tok_proc) begin
         if (emit) begin
            b_d   = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (accept && (bus.cfg_ratio != '0)) begin
               ratio_d = bus.cfg_ratio;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (boundary) begin
                  ratio_d = bus.cfg_ratio;
                  cnt_d   = '0;
                  state_d = (bus.cfg_ratio != '0) ? S_RUN : S_IDLE;
               end else begin
                  pend_ratio_d = bus.cfg_ratio;
                  state_d      = S_PEND;
               end
            end
         end
         S_PEND: begin
            if (emit) begin
               ratio_d = pend_ratio_q;
               cnt_d   = '0;
               state_d = (pend_ratio_q != '0) ? S_RUN : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q      <= S_IDLE;
         ratio_q      <= '0;
         pend_ratio_q <= '0;
         cnt_q        <= '0;
         b_q          <= 1'b0;
      end else begin
         state_q      <= state_d;
         ratio_q      <= ratio_d;
         pend_ratio_q <= pend_ratio_d;
         cnt_q        <= cnt_d;
         b_q          <= b_d;
      end
   end

`ifdef TOKEN_DECIM_STATS_EN
   logic [STAT_W-1:0] tok_in_q, tok_in_d;
   logic [STAT_W-1:0] tok_out_q, tok_out_d;

   always_comb begin
      tok_in_d  = tok_in_q;
      tok_out_d = tok_out_q;
      if (bus.stat_clr) begin
         tok_in_d  = '0;
         tok_out_d = '0;
      end else begin
         if (tok_proc && (tok_in_q != '1)) tok_in_d  = tok_in_q + STAT_W'(1);
         if (emit && (tok_out_q != '1))    tok_out_d = tok_out_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tok_in_q  <= '0;
         tok_out_q <= '0;
      end else begin
         tok_in_q  <= tok_in_d;
         tok_out_q <= tok_out_d;
      end
   end

   assign bus.tok_in_cnt  = tok_in_q;
   assign bus.tok_out_cnt = tok_out_q;
`else
   assign bus.tok_in_cnt  = '0;
   assign bus.tok_out_cnt = '0;
`endif

endmodule
